// File: rtl/pulse_timer_bank_if.sv
// pulse_timer_bank_if: control and status bundle for the pulse/PWM timer bank.
// The master side (controller) drives enables, modes, triggers and per-channel
// period/width words; the slave side (the timer bank) returns out/busy/wrap.
// Per-channel words are packed as channel i = ticks[i*N +: N], same for width.
interface pulse_timer_bank_if #(
  parameter int N        = 8,
  parameter int CHANNELS = 4
);
  logic                  ena;
  logic [CHANNELS-1:0]   ch_ena;
  logic [CHANNELS-1:0]   mode;
  logic [CHANNELS-1:0]   start;
  logic [CHANNELS*N-1:0] ticks;
  logic [CHANNELS*N-1:0] width;
  logic [CHANNELS-1:0]   out;
  logic [CHANNELS-1:0]   busy;
  logic [CHANNELS-1:0]   wrap;

  modport master (
    output ena, ch_ena, mode, start, ticks, width,
    input  out, busy, wrap
  );

  modport slave (
    input  ena, ch_ena, mode, start, ticks, width,
    output out, busy, wrap
  );
endinterface

// File: rtl/pulse_timer_bank.sv
// pulse_timer_bank: CHANNELS independent pulse/PWM generators on one clock.
// Each channel is periodic (free-running) or one-shot (one period per start).
// Period and high-width are double-buffered in shadow registers that load only
// when a channel starts and at every wrap, so mid-period writes never glitch.
// Optional build macro PULSE_TIMER_RETRIGGER_EN: when defined, a start seen by a
// running one-shot channel restarts its period with freshly loaded shadows;
// when undefined, such a start is ignored and the current period completes.
module pulse_timer_bank #(
  parameter int N        = 8,
  parameter int CHANNELS = 4
) (
  input  logic              clk,
  input  logic              rst,
  pulse_timer_bank_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state_q [CHANNELS];
  state_t         state_d [CHANNELS];
  logic [N-1:0]   cnt_q   [CHANNELS];
  logic [N-1:0]   cnt_d   [CHANNELS];
  logic [N-1:0]   tick_sh [CHANNELS];
  logic [N-1:0]   tick_d  [CHANNELS];
  logic [N-1:0]   wid_sh  [CHANNELS];
  logic [N-1:0]   wid_d   [CHANNELS];

  logic [CHANNELS-1:0] out_v;
  logic [CHANNELS-1:0] busy_v;
  logic [CHANNELS-1:0] wrap_v;

  // State, counter and shadow registers for every channel; rst is active-low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        tick_sh[i] <= '0;
        wid_sh[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        tick_sh[i] <= tick_d[i];
        wid_sh[i]  <= wid_d[i];
      end
    end
  end

  // Per-channel next state: start-up, counting, wrap/reload, stop and one-shot end.
  // A global ena=0 freezes running channels but still lets idle ones start.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      tick_d[i]  = tick_sh[i];
      wid_d[i]   = wid_sh[i];
      case (state_q[i])
        IDLE: begin
          if (bus.ch_ena[i] && (!bus.mode[i] || bus.start[i])) begin
            state_d[i] = RUN;
            cnt_d[i]   = '0;
            tick_d[i]  = bus.ticks[i*N +: N];
            wid_d[i]   = bus.width[i*N +: N];
          end
        end
        RUN: begin
          if (bus.ena && !bus.ch_ena[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end
`ifdef PULSE_TIMER_RETRIGGER_EN
          else if (bus.ch_ena[i] && bus.mode[i] && bus.start[i]) begin
            cnt_d[i]  = '0;
            tick_d[i] = bus.ticks[i*N +: N];
            wid_d[i]  = bus.width[i*N +: N];
          end
`endif
          else if (bus.ena) begin
            if (cnt_q[i] == tick_sh[i]) begin
              cnt_d[i] = '0;
              if (bus.mode[i]) begin
                state_d[i] = IDLE;
              end else begin
                tick_d[i] = bus.ticks[i*N +: N];
                wid_d[i]  = bus.width[i*N +: N];
              end
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Outputs decode straight from the registers; wrap is suppressed while frozen.
  always_comb begin
    out_v  = '0;
    busy_v = '0;
    wrap_v = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      busy_v[i] = (state_q[i] == RUN);
      out_v[i]  = busy_v[i] && (cnt_q[i] < wid_sh[i]);
      wrap_v[i] = busy_v[i] && bus.ena && (cnt_q[i] == tick_sh[i]);
    end
  end

  assign bus.out  = out_v;
  assign bus.busy = busy_v;
  assign bus.wrap = wrap_v;

endmodule

// File: tb/tb_pulse_timer_bank.sv
// tb_pulse_timer_bank: directed scenarios plus a randomized run, each cycle
// compared against a period/age reference model of every channel.
module tb_pulse_timer_bank;
  localparam int N  = 8;
  localparam int CH = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pulse_timer_bank_if #(.N(N), .CHANNELS(CH)) bus ();

  pulse_timer_bank #(.N(N), .CHANNELS(CH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int testCount = 0;
  int failCount = 0;

  logic          enaV;
  logic [CH-1:0] chEnaV;
  logic [CH-1:0] modeV;
  logic [CH-1:0] startV;
  int            tickV [CH];
  int            widV  [CH];

  bit mActive [CH];
  int mAge    [CH];
  int mLen    [CH];
  int mHi     [CH];

  int outHigh  [CH];
  int wrapHigh [CH];
  int busyHigh [CH];

  task automatic applyStimulus();
    bus.ena    = enaV;
    bus.ch_ena = chEnaV;
    bus.mode   = modeV;
    bus.start  = startV;
    for (int c = 0; c < CH; c++) begin
      bus.ticks[c*N +: N] = N'(tickV[c]);
      bus.width[c*N +: N] = N'(widV[c]);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    for (int c = 0; c < CH; c++) begin
      mActive[c] = 1'b0;
      mAge[c]    = 0;
      mLen[c]    = 1;
      mHi[c]     = 0;
    end
  endtask

  task automatic clearCounts();
    for (int c = 0; c < CH; c++) begin
      outHigh[c]  = 0;
      wrapHigh[c] = 0;
      busyHigh[c] = 0;
    end
  endtask

  task automatic clearInputs();
    enaV   = 1'b1;
    chEnaV = '0;
    modeV  = '0;
    startV = '0;
    for (int c = 0; c < CH; c++) begin
      tickV[c] = 0;
      widV[c]  = 0;
    end
  endtask

  // Reference model: a running channel is "age" cycles into a period of mLen
  // cycles whose first mHi cycles are high; new period parameters are taken
  // when a period begins.
  task automatic modelEdge();
    for (int c = 0; c < CH; c++) begin
      if (!mActive[c]) begin
        if (chEnaV[c] && (!modeV[c] || startV[c])) begin
          mActive[c] = 1'b1;
          mAge[c]    = 0;
          mLen[c]    = tickV[c] + 1;
          mHi[c]     = widV[c];
        end
      end else if (enaV && !chEnaV[c]) begin
        mActive[c] = 1'b0;
        mAge[c]    = 0;
      end
`ifdef PULSE_TIMER_RETRIGGER_EN
      else if (chEnaV[c] && modeV[c] && startV[c]) begin
        mAge[c] = 0;
        mLen[c] = tickV[c] + 1;
        mHi[c]  = widV[c];
      end
`endif
      else if (enaV) begin
        if (mAge[c] == mLen[c] - 1) begin
          mAge[c] = 0;
          if (modeV[c]) begin
            mActive[c] = 1'b0;
          end else begin
            mLen[c] = tickV[c] + 1;
            mHi[c]  = widV[c];
          end
        end else begin
          mAge[c]++;
        end
      end
    end
  endtask

  task automatic step();
    logic [CH-1:0] expOut, expBusy, expWrap;
    @(negedge clk);
    applyStimulus();
    #1;
    for (int c = 0; c < CH; c++) begin
      expBusy[c] = mActive[c];
      expOut[c]  = mActive[c] && (mAge[c] < mHi[c]);
      expWrap[c] = mActive[c] && enaV && (mAge[c] == mLen[c] - 1);
      outHigh[c]  += int'(bus.out[c]);
      wrapHigh[c] += int'(bus.wrap[c]);
      busyHigh[c] += int'(bus.busy[c]);
    end
    checkOutput("out", bus.out, expOut);
    checkOutput("busy", bus.busy, expBusy);
    checkOutput("wrap", bus.wrap, expWrap);
    @(posedge clk);
    modelEdge();
  endtask

  task automatic resetDut();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_out", bus.out, '0);
    checkOutput("rst_busy", bus.busy, '0);
    checkOutput("rst_wrap", bus.wrap, '0);
    clearModel();
    clearInputs();
    applyStimulus();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    clearInputs();
    clearModel();
    clearCounts();
    applyStimulus();
    #1;
    checkOutput("init_out", bus.out, '0);
    checkOutput("init_busy", bus.busy, '0);
    checkOutput("init_wrap", bus.wrap, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // periodic ch0 ticks=4 width=1
    chEnaV[0] = 1'b1; tickV[0] = 4; widV[0] = 1;
    step();
    clearCounts();
    repeat (10) step();
    checkInt("t1_out_count", outHigh[0], 2);
    checkInt("t1_wrap_count", wrapHigh[0], 2);

    // periodic ch1 ticks=9 width=3, width rewritten to 7 at count 5
    resetDut();
    chEnaV[1] = 1'b1; tickV[1] = 9; widV[1] = 3;
    step();
    clearCounts();
    repeat (5) step();
    widV[1] = 7;
    repeat (5) step();
    checkInt("t2_first_out", outHigh[1], 3);
    checkInt("t2_first_wrap", wrapHigh[1], 1);
    clearCounts();
    repeat (10) step();
    checkInt("t2_second_out", outHigh[1], 7);
    checkInt("t2_second_wrap", wrapHigh[1], 1);

    // one-shot ch2 ticks=3 width=2, then a second start at count 1
    resetDut();
    chEnaV[2] = 1'b1; modeV[2] = 1'b1; tickV[2] = 3; widV[2] = 2;
    step();
    startV[2] = 1'b1;
    clearCounts();
    step();
    startV[2] = 1'b0;
    repeat (6) step();
    checkInt("t3_busy", busyHigh[2], 4);
    checkInt("t3_out", outHigh[2], 2);
    checkInt("t3_wrap", wrapHigh[2], 1);
    clearCounts();
    startV[2] = 1'b1;
    step();
    startV[2] = 1'b0;
    step();
    startV[2] = 1'b1;
    step();
    startV[2] = 1'b0;
    repeat (6) step();
`ifdef PULSE_TIMER_RETRIGGER_EN
    checkInt("t3_retrig_busy", busyHigh[2], 6);
    checkInt("t3_retrig_out", outHigh[2], 4);
`else
    checkInt("t3_retrig_busy", busyHigh[2], 4);
    checkInt("t3_retrig_out", outHigh[2], 2);
`endif
    checkInt("t3_retrig_wrap", wrapHigh[2], 1);

    // ena=0 for 3 cycles mid-period, ch0 ticks=7 width=4
    resetDut();
    chEnaV[0] = 1'b1; tickV[0] = 7; widV[0] = 4;
    step();
    clearCounts();
    repeat (2) step();
    enaV = 1'b0;
    repeat (3) step();
    enaV = 1'b1;
    repeat (6) step();
    checkInt("t4_out", outHigh[0], 7);
    checkInt("t4_wrap", wrapHigh[0], 1);
    checkOutput("t4_last_wrap", bus.wrap & 4'b0001, 4'b0001);

    // asynchronous reset mid-count, then restart from count 0
    resetDut();
    chEnaV[0] = 1'b1; tickV[0] = 7; widV[0] = 4;
    step();
    repeat (2) step();
    resetDut();
    chEnaV[0] = 1'b1; tickV[0] = 7; widV[0] = 4;
    step();
    clearCounts();
    repeat (8) step();
    checkInt("t5_out", outHigh[0], 4);
    checkInt("t5_wrap", wrapHigh[0], 1);

    // edge cases: width 0, width above period, single-cycle period
    resetDut();
    chEnaV = 4'b1011;
    tickV[0] = 4;  widV[0] = 0;
    tickV[1] = 10; widV[1] = 255;
    tickV[3] = 0;  widV[3] = 1;
    step();
    clearCounts();
    repeat (11) step();
    checkInt("t6_w0_out", outHigh[0], 0);
    checkInt("t6_wmax_out", outHigh[1], 11);
    checkInt("t6_wmax_wrap", wrapHigh[1], 1);
    checkInt("t6_t0_wrap", wrapHigh[3], 11);
    checkInt("t6_t0_out", outHigh[3], 11);

    // randomized run against the model
    resetDut();
    for (int c = 0; c < CH; c++) begin
      tickV[c] = $urandom_range(0, 12);
      widV[c]  = $urandom_range(0, 14);
    end
    chEnaV = 4'b1111;
    for (int k = 0; k < 600; k++) begin
      enaV = ($urandom_range(0, 9) != 0);
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 19) == 0) modeV[c] = ~modeV[c];
        if (enaV && $urandom_range(0, 29) == 0) chEnaV[c] = ~chEnaV[c];
        startV[c] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 9) == 0) tickV[c] = $urandom_range(0, 12);
        if ($urandom_range(0, 9) == 0) widV[c] = $urandom_range(0, 14);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
